dsp_threshold_detector: RTL and testbench
=========================================

# dsp_threshold_detector

Streaming event detector that consumes the 32-bit threshold word driven by the HPS-writable DSP threshold PIO and applies it to the DSP sample stream. Each accepted signed sample is converted to a magnitude and compared against a trigger level and a release level, which gives hysteresis. A minimum-run qualifier and a post-event holdoff are applied. Each completed event is reported to the downstream capture/IRQ logic as a one-entry record with a valid/ready handshake.

## Interface
Parameters:
- MIN_RUN, 4: consecutive samples with magnitude >= trigger required to qualify an event; legal range 1..255.
- HOLDOFF, 64: accepted samples ignored after an event completes; legal range 0..65535.
- CNT_W, 16: width of the event length counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- threshold  in  32  [15:0] is the trigger level (unsigned magnitude); [31:16] is the release level (unsigned magnitude).
- enable  in  1  detector run control.
- in_valid  in  1  sample strobe. There is no backpressure; a sample is accepted when in_valid && enable.
- in_data  in  16  signed two's-complement sample.
- evt_valid  out  1  an event record is pending.
- evt_ready  in  1  the consumer accepts the record when evt_valid && evt_ready.
- evt_start  out  32  sample index of the first sample of the qualifying run.
- evt_length  out  CNT_W  number of samples in the event.
- evt_peak  out  16  maximum magnitude seen during the event.
- busy  out  1  state is QUALIFY, ACTIVE or HOLDOFF.
- overflow_cnt  out  8  count of events dropped; saturates at 255.
- sample_cnt  out  32  count of accepted samples.

## Operation
- Magnitude: mag = |in_data|, with -32768 saturating to 32767.
- Levels:
  - trig = threshold[15:0].
  - rel = min(threshold[31:16], trig).
  - Both levels are read on every accepted sample.
- sample_cnt increments on each accepted sample and wraps at 2^32. It clears while enable = 0.
- State machine: IDLE, ARMED, QUALIFY, ACTIVE, HOLDOFF. All transitions except those into IDLE occur only on accepted samples.
- IDLE: entered whenever enable = 0, regardless of state. Run and holdoff counters clear. Moves to ARMED on the first cycle with enable = 1.
- ARMED: when mag >= trig:
  - Set run = 1, peak = mag, start = sample_cnt (the value before increment).
  - If MIN_RUN == 1, go to ACTIVE with length = 1; otherwise go to QUALIFY.
- QUALIFY:
  - mag >= trig: run++ and peak = max(peak, mag). When run reaches MIN_RUN, go to ACTIVE with length = MIN_RUN.
  - mag < trig: return to ARMED and discard the run.
- ACTIVE:
  - mag > rel: length++ (saturating at all-ones) and peak = max.
  - mag <= rel: the event completes; the release sample is not counted. Emit the record. Go to HOLDOFF with hcnt = HOLDOFF, or directly to ARMED if HOLDOFF == 0.
- HOLDOFF: hcnt-- on each accepted sample, without comparison. Move to ARMED after the sample that takes hcnt to 0.
- Event register (one entry):
  - On completion it loads if evt_valid == 0, or if evt_valid && evt_ready in the same cycle.
  - Otherwise the new event is dropped and overflow_cnt increments (saturating at 255). The pending record is unchanged.
- The event register and overflow_cnt are unaffected by enable. A record pending when enable drops stays valid until accepted.

## Timing
- Reset values: all outputs 0, state IDLE, all internal counters 0.
- Latency: the release sample accepted at edge k produces evt_valid = 1 with the record fields stable after edge k. Completion is therefore 1 cycle after the sample is presented.
- evt_valid stays high and the record fields stay stable until the edge on which evt_ready = 1. evt_valid falls after that edge unless a new completion loads on the same edge.
- enable falling at edge k: state is IDLE after edge k. A sample presented on that cycle is not accepted. An in-progress run or event is abandoned without a record.
- Threshold changes take effect on the next accepted sample. There is no shadowing, so software disables the detector before changing levels.
- Back-to-back samples, one per cycle, are sustained indefinitely.
- reset_n assertion mid-event clears everything asynchronously. No record is emitted.

## Test plan
- Basic event: threshold = 0x0064_00C8 (trig 200, rel 100), MIN_RUN = 4, HOLDOFF = 2, evt_ready = 1. Samples 0,250,300,-400,220,150,90,500,500 -> one record with start = 1, length = 5, peak = 400; samples 7 and 8 are ignored by holdoff; overflow_cnt = 0.
- Qualifier reject: same levels, samples 250,250,250,10,0 -> no evt_valid; state returns to ARMED; busy falls after the sample 10.
- Saturation and min(): in_data = -32768 with trig 0x7FFF and rel 0xFFFF (release clamps to 0x7FFF), MIN_RUN = 1 -> event qualifies; the next sample 0x7FFF completes it with peak = 0x7FFF and length = 1.
- Backpressure: evt_ready = 0 and two events complete -> the first record is held unchanged and overflow_cnt = 1. Raising evt_ready for one cycle drops evt_valid.
- Simultaneous accept and load: evt_ready = 1 on the same cycle as a completion -> evt_valid stays high with the new record; overflow_cnt is unchanged.
- Disable mid-event: enable falls while in ACTIVE -> IDLE on the next cycle, sample_cnt = 0, no record. After re-enable, a fresh event starts with start = 0 relative to the new count.

Source files
------------

// File: rtl/dsp_threshold_detector_if.sv
// Sample stream in and one-entry event record out for the threshold detector.
// The detector connects through the slave modport; the source/consumer side uses master.
interface dsp_threshold_detector_if #(
   parameter int CNT_W = 16
) ();
   logic                    in_valid;
   logic signed [15:0]      in_data;
   logic                    evt_valid;
   logic                    evt_ready;
   logic [31:0]             evt_start;
   logic [CNT_W-1:0]        evt_length;
   logic [15:0]             evt_peak;

   modport master (
      output in_valid, in_data, evt_ready,
      input  evt_valid, evt_start, evt_length, evt_peak
   );

   modport slave (
      input  in_valid, in_data, evt_ready,
      output evt_valid, evt_start, evt_length, evt_peak
   );
endinterface

// File: rtl/dsp_threshold_detector.sv
// Magnitude threshold event detector: hysteresis, minimum-run qualifier and holdoff,
// reporting each completed event through a one-entry valid/ready record register.
module dsp_threshold_detector #(
   parameter int MIN_RUN = 4,
   parameter int HOLDOFF = 64,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [31:0]             threshold,
   input  logic                    enable,
   dsp_threshold_detector_if.slave bus,
   output logic                    busy,
   output logic [7:0]              overflow_cnt,
   output logic [31:0]             sample_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_QUALIFY,
      S_ACTIVE,
      S_HOLDOFF
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      sample_cnt_q, sample_cnt_d;
   logic [7:0]       run_q, run_d;
   logic [15:0]      hcnt_q, hcnt_d;
   logic [31:0]      cur_start_q, cur_start_d;
   logic [CNT_W-1:0] cur_len_q, cur_len_d;
   logic [15:0]      cur_peak_q, cur_peak_d;
   logic             evt_valid_q, evt_valid_d;
   logic [31:0]      evt_start_q, evt_start_d;
   logic [CNT_W-1:0] evt_length_q, evt_length_d;
   logic [15:0]      evt_peak_q, evt_peak_d;
   logic [7:0]       ovf_q, ovf_d;

   logic        accept;
   logic        complete;
   logic [15:0] raw, mag, trig, rel, peak_max;

   assign accept   = bus.in_valid && enable;
   assign raw      = bus.in_data;
   // The most negative sample has no positive counterpart, so it saturates.
   assign mag      = (raw == 16'h8000) ? 16'h7FFF : (raw[15] ? (~raw + 16'd1) : raw);
   assign trig     = threshold[15:0];
   assign rel      = (threshold[31:16] < trig) ? threshold[31:16] : trig;
   assign peak_max = (mag > cur_peak_q) ? mag : cur_peak_q;

   always_comb begin
      // NOTE: every _d starts from its _q so branches that skip a signal never infer a latch.
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      run_d        = run_q;
      hcnt_d       = hcnt_q;
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      cur_peak_d   = cur_peak_q;
      evt_valid_d  = evt_valid_q;
      evt_start_d  = evt_start_q;
      evt_length_d = evt_length_q;
      evt_peak_d   = evt_peak_q;
      ovf_d        = ovf_q;
      complete     = 1'b0;

      if (!enable) begin
         state_d      = S_IDLE;
         run_d        = '0;
         hcnt_d       = '0;
         sample_cnt_d = '0;
      end else begin
         if (accept) sample_cnt_d = sample_cnt_q + 32'd1;
         unique case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: begin
               if (accept && mag >= trig) begin
                  run_d       = 8'd1;
                  cur_peak_d  = mag;
                  cur_start_d = sample_cnt_q;
                  if (MIN_RUN == 1) begin
                     state_d   = S_ACTIVE;
                     cur_len_d = CNT_W'(MIN_RUN);
                  end else begin
                     state_d = S_QUALIFY;
                  end
               end
            end
            S_QUALIFY: begin
               if (accept) begin
                  if (mag >= trig) begin
                     run_d      = run_q + 8'd1;
                     cur_peak_d = peak_max;
                     if (run_q + 8'd1 == 8'(MIN_RUN)) begin
                        state_d   = S_ACTIVE;
                        cur_len_d = CNT_W'(MIN_RUN);
                     end
                  end else begin
                     state_d = S_ARMED;
                     run_d   = '0;
                  end
               end
            end
            S_ACTIVE: begin
               if (accept) begin
                  if (mag > rel) begin
                     if (cur_len_q != '1) cur_len_d = cur_len_q + 1'b1;
                     cur_peak_d = peak_max;
                  end else begin
                     // The release sample ends the event but is not part of it.
                     complete = 1'b1;
                     if (HOLDOFF == 0) begin
                        state_d = S_ARMED;
                     end else begin
                        state_d = S_HOLDOFF;
                        hcnt_d  = 16'(HOLDOFF);
                     end
                  end
               end
            end
            S_HOLDOFF: begin
               if (accept) begin
                  hcnt_d = hcnt_q - 16'd1;
                  if (hcnt_q == 16'd1) state_d = S_ARMED;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (evt_valid_q && bus.evt_ready) evt_valid_d = 1'b0;
      if (complete) begin
         if (!evt_valid_q || bus.evt_ready) begin
            evt_valid_d  = 1'b1;
            evt_start_d  = cur_start_q;
            evt_length_d = cur_len_q;
            evt_peak_d   = cur_peak_q;
         end else if (ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
         end
      end
   end

   // NOTE: sequential state uses <= so every flop updates from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         sample_cnt_q <= '0;
         run_q        <= '0;
         hcnt_q       <= '0;
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         cur_peak_q   <= '0;
         evt_valid_q  <= 1'b0;
         evt_start_q  <= '0;
         evt_length_q <= '0;
         evt_peak_q   <= '0;
         ovf_q        <= '0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         run_q        <= run_d;
         hcnt_q       <= hcnt_d;
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         cur_peak_q   <= cur_peak_d;
         evt_valid_q  <= evt_valid_d;
         evt_start_q  <= evt_start_d;
         evt_length_q <= evt_length_d;
         evt_peak_q   <= evt_peak_d;
         ovf_q        <= ovf_d;
      end
   end

   assign bus.evt_valid  = evt_valid_q;
   assign bus.evt_start  = evt_start_q;
   assign bus.evt_length = evt_length_q;
   assign bus.evt_peak   = evt_peak_q;
   assign busy           = (state_q == S_QUALIFY) || (state_q == S_ACTIVE) || (state_q == S_HOLDOFF);
   assign overflow_cnt   = ovf_q;
   assign sample_cnt     = sample_cnt_q;

endmodule

// File: tb/tb_dsp_threshold_detector.sv
// Bench for dsp_threshold_detector: two instances (MIN_RUN 4/HOLDOFF 2 and MIN_RUN 1/HOLDOFF 0)
// share one stimulus stream and are compared every cycle against a sample-level reference model.
module tb_dsp_threshold_detector;

   logic               clk;
   logic               reset_n;
   logic [31:0]        threshold;
   logic               enable;
   logic               in_valid;
   logic signed [15:0] in_data;
   logic               evt_ready;

   logic        busy0, busy1;
   logic [7:0]  ovf0, ovf1;
   logic [31:0] scnt0, scnt1;

   int total = 0;
   int bad   = 0;

   dsp_threshold_detector_if #(.CNT_W(16)) bus0 ();
   dsp_threshold_detector_if #(.CNT_W(16)) bus1 ();

   assign bus0.in_valid  = in_valid;
   assign bus0.in_data   = in_data;
   assign bus0.evt_ready = evt_ready;
   assign bus1.in_valid  = in_valid;
   assign bus1.in_data   = in_data;
   assign bus1.evt_ready = evt_ready;

   dsp_threshold_detector #(.MIN_RUN(4), .HOLDOFF(2), .CNT_W(16)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .threshold(threshold), .enable(enable),
      .bus(bus0), .busy(busy0), .overflow_cnt(ovf0), .sample_cnt(scnt0)
   );

   dsp_threshold_detector #(.MIN_RUN(1), .HOLDOFF(0), .CNT_W(16)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .threshold(threshold), .enable(enable),
      .bus(bus1), .busy(busy1), .overflow_cnt(ovf1), .sample_cnt(scnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, one slot per instance.
   bit [31:0] m_cnt   [2];
   bit        m_live  [2];
   int        m_run   [2];
   bit        m_evt   [2];
   int        m_len   [2];
   int        m_peak  [2];
   bit [31:0] m_start [2];
   int        m_hold  [2];
   bit        r_valid [2];
   bit [31:0] r_start [2];
   int        r_len   [2];
   int        r_peak  [2];
   int        r_ovf   [2];

   function automatic int min_run(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int holdoff(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_live[i] = 0; m_run[i] = 0; m_evt[i] = 0; m_len[i] = 0;
         m_peak[i] = 0; m_start[i] = 0; m_hold[i] = 0;
         r_valid[i] = 0; r_start[i] = 0; r_len[i] = 0; r_peak[i] = 0; r_ovf[i] = 0;
      end
   endtask

   // Applies one clock edge worth of the detector's rules to the model.
   task automatic model_edge();
      int  x, mag, trig, rel;
      bit  acc, done, pop;
      x    = int'(in_data);
      mag  = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
      trig = int'(threshold[15:0]);
      rel  = (int'(threshold[31:16]) < trig) ? int'(threshold[31:16]) : trig;
      acc  = in_valid && enable;
      for (int i = 0; i < 2; i++) begin
         done = 0;
         pop  = r_valid[i] && evt_ready;
         if (!enable) begin
            m_live[i] = 0; m_run[i] = 0; m_evt[i] = 0; m_hold[i] = 0; m_cnt[i] = 0;
         end else if (!m_live[i]) begin
            m_live[i] = 1;
            if (acc) m_cnt[i] = m_cnt[i] + 1;
         end else if (acc) begin
            if (m_hold[i] > 0) begin
               m_hold[i]--;
            end else if (m_evt[i]) begin
               if (mag > rel) begin
                  if (m_len[i] < 65535) m_len[i]++;
                  if (mag > m_peak[i]) m_peak[i] = mag;
               end else begin
                  done = 1; m_evt[i] = 0; m_hold[i] = holdoff(i);
               end
            end else if (mag >= trig) begin
               if (m_run[i] == 0) begin
                  m_start[i] = m_cnt[i]; m_peak[i] = mag;
               end else if (mag > m_peak[i]) begin
                  m_peak[i] = mag;
               end
               m_run[i]++;
               if (m_run[i] == min_run(i)) begin
                  m_evt[i] = 1; m_len[i] = min_run(i); m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
            m_cnt[i] = m_cnt[i] + 1;
         end
         if (pop) r_valid[i] = 0;
         if (done) begin
            if (!r_valid[i]) begin
               r_valid[i] = 1; r_start[i] = m_start[i]; r_len[i] = m_len[i]; r_peak[i] = m_peak[i];
            end else if (r_ovf[i] < 255) begin
               r_ovf[i]++;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_unit(input int i, input logic ev, input logic [31:0] st, input logic [15:0] ln,
                             input logic [15:0] pk, input logic bz, input logic [7:0] ov,
                             input logic [31:0] sc);
      bit exp_busy;
      exp_busy = m_live[i] && (m_run[i] > 0 || m_evt[i] || m_hold[i] > 0);
      check($sformatf("u%0d.evt_valid", i),    {31'd0, ev}, {31'd0, r_valid[i]});
      check($sformatf("u%0d.evt_start", i),    st, r_start[i]);
      check($sformatf("u%0d.evt_length", i),   {16'd0, ln}, 32'(r_len[i]));
      check($sformatf("u%0d.evt_peak", i),     {16'd0, pk}, 32'(r_peak[i]));
      check($sformatf("u%0d.busy", i),         {31'd0, bz}, {31'd0, exp_busy});
      check($sformatf("u%0d.overflow_cnt", i), {24'd0, ov}, 32'(r_ovf[i]));
      check($sformatf("u%0d.sample_cnt", i),   sc, m_cnt[i]);
   endtask

   task automatic compare_all();
      check_unit(0, bus0.evt_valid, bus0.evt_start, bus0.evt_length, bus0.evt_peak, busy0, ovf0, scnt0);
      check_unit(1, bus1.evt_valid, bus1.evt_start, bus1.evt_length, bus1.evt_peak, busy1, ovf1, scnt1);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic smp(input logic v, input int d);
      in_valid = v;
      in_data  = 16'(d);
      cycle();
   endtask

   task automatic restart(input logic [31:0] thr);
      enable = 1'b0;
      smp(1'b0, 0);
      threshold = thr;
      enable    = 1'b1;
      smp(1'b0, 0);
   endtask

   task automatic samples(input int d, input int n);
      for (int k = 0; k < n; k++) smp(1'b1, d);
   endtask

   initial begin
      int d;
      logic v;
      reset_n   = 1'b0;
      threshold = '0;
      enable    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      evt_ready = 1'b1;
      model_reset();

      #12;
      compare_all();
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Basic event: start 1, length 5, peak 400; 500s fall in the holdoff window.
      restart(32'h0064_00C8);
      smp(1, 0); smp(1, 250); smp(1, 300); smp(1, -400); smp(1, 220); smp(1, 150); smp(1, 90);
      check("basic.valid",  {31'd0, bus0.evt_valid}, 32'd1);
      check("basic.start",  bus0.evt_start, 32'd1);
      check("basic.length", {16'd0, bus0.evt_length}, 32'd5);
      check("basic.peak",   {16'd0, bus0.evt_peak}, 32'd400);
      smp(1, 500);
      check("basic.holdoff_busy", {31'd0, busy0}, 32'd1);
      smp(1, 500);
      smp(0, 0);
      check("basic.ovf", {24'd0, ovf0}, 32'd0);

      // Qualifier reject.
      restart(32'h0064_00C8);
      samples(250, 3);
      check("reject.busy_mid", {31'd0, busy0}, 32'd1);
      smp(1, 10);
      check("reject.busy_after", {31'd0, busy0}, 32'd0);
      smp(1, 0);
      check("reject.no_valid", {31'd0, bus0.evt_valid}, 32'd0);

      // Saturated magnitude and clamped release level.
      restart(32'hFFFF_7FFF);
      smp(1, -32768);
      check("sat.active", {31'd0, busy1}, 32'd1);
      smp(1, 32767);
      check("sat.valid",  {31'd0, bus1.evt_valid}, 32'd1);
      check("sat.peak",   {16'd0, bus1.evt_peak}, 32'h7FFF);
      check("sat.length", {16'd0, bus1.evt_length}, 32'd1);

      // Backpressure: the second event is dropped, the first record is held.
      restart(32'h0064_00C8);
      evt_ready = 1'b0;
      samples(250, 4); smp(1, 90);
      samples(0, 2);
      samples(300, 4); smp(1, 90);
      check("bp.start", bus0.evt_start, 32'd0);
      check("bp.peak",  {16'd0, bus0.evt_peak}, 32'd250);
      check("bp.ovf",   {24'd0, ovf0}, 32'd1);
      evt_ready = 1'b1;
      smp(0, 0);
      evt_ready = 1'b0;
      check("bp.drop", {31'd0, bus0.evt_valid}, 32'd0);

      // Accept and load on the same edge.
      samples(0, 2);
      samples(250, 4); smp(1, 90);
      samples(0, 2);
      samples(300, 4);
      evt_ready = 1'b1;
      smp(1, 90);
      check("simul.valid", {31'd0, bus0.evt_valid}, 32'd1);
      check("simul.peak",  {16'd0, bus0.evt_peak}, 32'd300);
      check("simul.ovf",   {24'd0, ovf0}, 32'd1);
      smp(0, 0);

      // Disable mid-event, then a fresh event counted from zero.
      restart(32'h0064_00C8);
      samples(250, 4); smp(1, 220);
      enable = 1'b0;
      smp(1, 500);
      check("dis.busy", {31'd0, busy0}, 32'd0);
      check("dis.cnt",  scnt0, 32'd0);
      enable = 1'b1;
      smp(0, 0);
      samples(250, 4); smp(1, 90);
      check("dis.valid", {31'd0, bus0.evt_valid}, 32'd1);
      check("dis.start", bus0.evt_start, 32'd0);
      samples(0, 3);

      // Asynchronous reset mid-event.
      samples(250, 4); smp(1, 220);
      reset_n = 1'b0;
      #2;
      model_reset();
      compare_all();
      check("rst.busy", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      smp(0, 0);

      // Randomised traffic with random levels, backpressure and occasional disables.
      threshold = 32'h0064_00C8;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            enable    = 1'b0;
            threshold = {16'($urandom_range(0, 4000)), 16'($urandom_range(100, 3000))};
         end else begin
            enable = 1'b1;
         end
         evt_ready = 1'($urandom_range(0, 1));
         v = ($urandom_range(0, 4) != 0);
         case ($urandom_range(0, 9))
            0:       d = -32768;
            1:       d = 32767;
            default: d = int'($urandom_range(0, 8000)) - 4000;
         endcase
         smp(v, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
